// File: rtl/kv_way_allocator.sv
// Per-set valid/tree-PLRU owner granting one victim way per accepted alloc; optional KV_ALLOC_STATS_EN adds alloc/evict counters.
// Response one cycle after accept; ready drops while flushing, on flush request and in reset; hits/invs never stall.
module kv_way_allocator #(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 64,
  parameter int SET_W   = $clog2(SET_NUM)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_alloc_valid,
  output logic               o_alloc_ready,
  input  logic [SET_W-1:0]   i_alloc_set,
  output logic               o_resp_valid,
  output logic [WAY_NUM-1:0] o_resp_way,
  output logic               o_resp_evict,
  input  logic               i_hit_valid,
  input  logic [SET_W-1:0]   i_hit_set,
  input  logic [WAY_NUM-1:0] i_hit_way,
  input  logic               i_inv_valid,
  input  logic [SET_W-1:0]   i_inv_set,
  input  logic [WAY_NUM-1:0] i_inv_way,
  input  logic               i_flush,
  output logic               o_flush_busy
`ifdef KV_ALLOC_STATS_EN
  ,
  output logic [31:0]        o_evict_cnt,
  output logic [31:0]        o_alloc_cnt
`endif
);

  localparam int WAY_W = $clog2(WAY_NUM);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [SET_W-1:0]     flush_idx_q;
  logic                 flush_start, flush_busy, alloc_rdy, accept;
  logic [WAY_NUM-1:0]   valid_q [SET_NUM];
  logic [WAY_NUM-2:0]   plru_q  [SET_NUM];

  logic [WAY_NUM-1:0]   cur_v, inv_oh, plru_oh, victim, alloc_v_base, alloc_v_next;
  logic [WAY_NUM-2:0]   cur_p, hit_p_next, alloc_p_base, alloc_p_next;
  logic                 found, walk_bit, victim_evict, hit_en;
  int                   node;

  // Leaves are heap nodes WAY_NUM..2*WAY_NUM-1; every ancestor is pointed at the sibling subtree.
  function automatic logic [WAY_NUM-2:0] plru_touch(input logic [WAY_NUM-2:0] cur, input int leaf);
    logic [WAY_NUM-2:0] r;
    r = cur;
    for (int n = 1; n < WAY_NUM; n++)
      for (int s = 1; s <= WAY_W; s++)
        if ((leaf >> s) == n) r[n-1] = (((leaf >> (s - 1)) & 1) == 0);
    return r;
  endfunction

  function automatic int onehot_leaf(input logic [WAY_NUM-1:0] oh);
    int l;
    l = WAY_NUM;
    for (int w = 0; w < WAY_NUM; w++)
      if (oh[w]) l = WAY_NUM + w;
    return l;
  endfunction

  // Victim selection from pre-update state of the requested set
  always_comb begin
    cur_v    = valid_q[i_alloc_set];
    cur_p    = plru_q[i_alloc_set];
    inv_oh   = '0;
    found    = 1'b0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (!cur_v[w] && !found) begin
        inv_oh[w] = 1'b1;
        found     = 1'b1;
      end
    end
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      walk_bit = 1'b0;
      for (int n = 1; n < WAY_NUM; n++)
        if (n == node) walk_bit = cur_p[n-1];
      node = 2 * node + (walk_bit ? 1 : 0);
    end
    plru_oh = '0;
    for (int w = 0; w < WAY_NUM; w++)
      plru_oh[w] = (node == WAY_NUM + w);
    victim       = found ? inv_oh : plru_oh;
    victim_evict = ~found;
  end

  // Same-set hit/inv are folded in first so the alloc update lands on top of them
  always_comb begin
    hit_en       = i_hit_valid && (|i_hit_way);
    hit_p_next   = plru_touch(plru_q[i_hit_set], onehot_leaf(i_hit_way));
    alloc_p_base = (hit_en && (i_hit_set == i_alloc_set)) ? hit_p_next : cur_p;
    alloc_p_next = plru_touch(alloc_p_base, onehot_leaf(victim));
    alloc_v_base = (i_inv_valid && (i_inv_set == i_alloc_set)) ? (cur_v & ~i_inv_way) : cur_v;
    alloc_v_next = alloc_v_base | victim;
  end

  always_comb begin
    state_d     = state_q;
    flush_start = 1'b0;
    flush_busy  = 1'b0;
    alloc_rdy   = 1'b0;
    case (state_q)
      S_IDLE: begin
        alloc_rdy = ~i_flush;
        if (i_flush) begin
          state_d     = S_FLUSH;
          flush_start = 1'b1;
        end
      end
      S_FLUSH: begin
        flush_busy = 1'b1;
        if (flush_idx_q == SET_W'(SET_NUM - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_alloc_ready = alloc_rdy & ~i_rst;
  assign o_flush_busy  = flush_busy;
  assign accept        = i_alloc_valid & o_alloc_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    flush_idx_q <= '0;
    else if (flush_start)         flush_idx_q <= '0;
    else if (state_q == S_FLUSH)  flush_idx_q <= flush_idx_q + SET_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (state_q == S_FLUSH) begin
      valid_q[flush_idx_q] <= '0;
      plru_q[flush_idx_q]  <= '0;
    end else begin
      if (hit_en)      plru_q[i_hit_set]  <= hit_p_next;
      if (i_inv_valid) valid_q[i_inv_set] <= valid_q[i_inv_set] & ~i_inv_way;
      if (accept) begin
        valid_q[i_alloc_set] <= alloc_v_next;
        plru_q[i_alloc_set]  <= alloc_p_next;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_resp_valid <= 1'b0;
      o_resp_way   <= '0;
      o_resp_evict <= 1'b0;
    end else begin
      o_resp_valid <= accept;
      if (accept) begin
        o_resp_way   <= victim;
        o_resp_evict <= victim_evict;
      end
    end
  end

`ifdef KV_ALLOC_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_alloc_cnt <= '0;
      o_evict_cnt <= '0;
    end else if (flush_start) begin
      o_alloc_cnt <= '0;
      o_evict_cnt <= '0;
    end else if (accept) begin
      if (o_alloc_cnt != 32'hFFFF_FFFF) o_alloc_cnt <= o_alloc_cnt + 32'd1;
      if (victim_evict && (o_evict_cnt != 32'hFFFF_FFFF)) o_evict_cnt <= o_evict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kv_way_allocator.sv
// Directed bench for kv_way_allocator with a response scoreboard checked on the falling edge.
module tb_kv_way_allocator;

  logic       i_clk, i_rst;
  logic       i_alloc_valid, o_alloc_ready;
  logic [5:0] i_alloc_set;
  logic       o_resp_valid;
  logic [3:0] o_resp_way;
  logic       o_resp_evict;
  logic       i_hit_valid;
  logic [5:0] i_hit_set;
  logic [3:0] i_hit_way;
  logic       i_inv_valid;
  logic [5:0] i_inv_set;
  logic [3:0] i_inv_way;
  logic       i_flush, o_flush_busy;
`ifdef KV_ALLOC_STATS_EN
  logic [31:0] o_evict_cnt, o_alloc_cnt;
`endif

  kv_way_allocator #(.WAY_NUM(4), .SET_NUM(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready), .i_alloc_set(i_alloc_set),
    .o_resp_valid(o_resp_valid), .o_resp_way(o_resp_way), .o_resp_evict(o_resp_evict),
    .i_hit_valid(i_hit_valid), .i_hit_set(i_hit_set), .i_hit_way(i_hit_way),
    .i_inv_valid(i_inv_valid), .i_inv_set(i_inv_set), .i_inv_way(i_inv_way),
    .i_flush(i_flush), .o_flush_busy(o_flush_busy)
`ifdef KV_ALLOC_STATS_EN
    , .o_evict_cnt(o_evict_cnt), .o_alloc_cnt(o_alloc_cnt)
`endif
  );

  typedef struct {
    logic [3:0] way;
    logic       evict;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] w, input logic ev);
    exp_t e;
    e.way   = w;
    e.evict = ev;
    e.due   = cyc + 1;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: each response must match the oldest expectation, exactly one cycle after its accept
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("resp_late", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (o_resp_valid) begin
        if (q.size() == 0) begin
          chk("resp_unexpected", o_resp_valid, 1'b0);
        end else begin
          e = q.pop_front();
          chk("resp_way", o_resp_way, e.way);
          chk("resp_evict", o_resp_evict, e.evict);
          chk("resp_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    int         cnt;
    int         rdy_hi;
    logic [3:0] w;
    i_rst = 1'b1;
    i_alloc_valid = 1'b0; i_alloc_set = '0;
    i_hit_valid = 1'b0; i_hit_set = '0; i_hit_way = '0;
    i_inv_valid = 1'b0; i_inv_set = '0; i_inv_way = '0;
    i_flush = 1'b0;
    #12;
    chk("rst_ready", o_alloc_ready, 1'b0);
    chk("rst_resp_valid", o_resp_valid, 1'b0);
    chk("rst_resp_way", o_resp_way, 4'b0000);
    chk("rst_resp_evict", o_resp_evict, 1'b0);
    chk("rst_busy", o_flush_busy, 1'b0);
    step();
    i_rst = 1'b0;
    #1;
    chk("ready_after_rst", o_alloc_ready, 1'b1);

    // Fill set 5, then PLRU victim, then hit-steered victim
    i_alloc_valid = 1'b1; i_alloc_set = 6'd5;
    for (int k = 0; k < 4; k++) begin
      w = 4'b0001 << k;
      chk("fill5_ready", o_alloc_ready, 1'b1);
      push(w, 1'b0);
      step();
    end
    push(4'b0001, 1'b1);
    step();
`ifdef KV_ALLOC_STATS_EN
    chk("stats_alloc_cnt", o_alloc_cnt, 32'd5);
    chk("stats_evict_cnt", o_evict_cnt, 32'd1);
`endif
    i_alloc_valid = 1'b0;
    i_hit_valid = 1'b1; i_hit_set = 6'd5; i_hit_way = 4'b0100;
    step();
    i_hit_valid = 1'b0;
    i_alloc_valid = 1'b1; i_alloc_set = 6'd5;
    push(4'b0010, 1'b1);
    step();

    // Set 9: same-cycle inv+alloc picks from pre-inv state
    i_alloc_set = 6'd9;
    for (int k = 0; k < 4; k++) begin
      w = 4'b0001 << k;
      push(w, 1'b0);
      step();
    end
    i_inv_valid = 1'b1; i_inv_set = 6'd9; i_inv_way = 4'b0100;
    push(4'b0001, 1'b1);
    step();
    i_inv_valid = 1'b0;
    push(4'b0100, 1'b0);
    step();

    // Fill sets 0 and 63 before flushing
    for (int j = 0; j < 2; j++) begin
      i_alloc_set = (j == 0) ? 6'd0 : 6'd63;
      for (int k = 0; k < 4; k++) begin
        w = 4'b0001 << k;
        push(w, 1'b0);
        step();
      end
    end
    i_alloc_valid = 1'b0;
    step();
    step();

    // Flush with a pending alloc request
    i_alloc_valid = 1'b1; i_alloc_set = 6'd3; i_flush = 1'b1;
    #1;
    chk("flush_req_ready", o_alloc_ready, 1'b0);
    step();
    i_flush = 1'b0;
    cnt = 0;
    rdy_hi = 0;
    while (o_flush_busy && cnt < 200) begin
      if (o_alloc_ready) rdy_hi++;
      cnt++;
      step();
    end
    i_alloc_valid = 1'b0;
    chk("flush_busy_cycles", cnt, 64);
    chk("flush_ready_high", rdy_hi, 0);
    i_alloc_valid = 1'b1;
    i_alloc_set = 6'd0;  push(4'b0001, 1'b0); step();
    i_alloc_set = 6'd63; push(4'b0001, 1'b0); step();
    i_alloc_set = 6'd9;  push(4'b0001, 1'b0); step();
    i_alloc_valid = 1'b0;
    step();
`ifdef KV_ALLOC_STATS_EN
    chk("stats_alloc_after_flush", o_alloc_cnt, 32'd3);
    chk("stats_evict_after_flush", o_evict_cnt, 32'd0);
`endif

    // Reset in the middle of a flush walk
    i_alloc_valid = 1'b1; i_alloc_set = 6'd40; push(4'b0001, 1'b0); step();
    i_alloc_valid = 1'b0;
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    repeat (10) step();
    chk("midflush_busy", o_flush_busy, 1'b1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_busy", o_flush_busy, 1'b0);
    chk("arst_resp_valid", o_resp_valid, 1'b0);
    chk("arst_resp_way", o_resp_way, 4'b0000);
    chk("arst_resp_evict", o_resp_evict, 1'b0);
    chk("arst_ready", o_alloc_ready, 1'b0);
    step();
    step();
    i_rst = 1'b0;
    #1;
    chk("post_rst_busy", o_flush_busy, 1'b0);
    i_alloc_valid = 1'b1; i_alloc_set = 6'd40; push(4'b0001, 1'b0); step();
    i_alloc_valid = 1'b0;
    step();
    step();
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kv_way_allocator.md
Name: kv_way_allocator

Overview:
- Per-set way allocation and replacement controller for the set-associative caches.
- Sits between cache miss handling and the tag/valid arrays.
- Owns the per-set valid bits and tree-PLRU state, and grants one victim way per allocation request.
- Selection order: lowest-index invalid way first, otherwise the PLRU victim. Also handles invalidations, hit-driven PLRU updates and a whole-cache flush walk.

Parameters:
- WAY_NUM, 4, ways per set; power of two, >=2
- SET_NUM, 64, sets; power of two, >=2
- SET_W, $clog2(SET_NUM), set index width (derived)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_alloc_valid  in  1  allocation request
- o_alloc_ready  out  1  request accepted when valid&ready
- i_alloc_set  in  SET_W  set to allocate in
- o_resp_valid  out  1  one-cycle response pulse
- o_resp_way  out  WAY_NUM  granted way, one-hot
- o_resp_evict  out  1  granted way held valid data (writeback/evict needed)
- i_hit_valid  in  1  hit notification
- i_hit_set  in  SET_W  hit set
- i_hit_way  in  WAY_NUM  hit way, one-hot
- i_inv_valid  in  1  invalidate request (always accepted)
- i_inv_set  in  SET_W  set to invalidate
- i_inv_way  in  WAY_NUM  way(s) to invalidate; multi-hot allowed
- i_flush  in  1  start flush (level-sampled in IDLE)
- o_flush_busy  out  1  flush walk in progress
- Interface decision: one clock `i_clk`; reset `i_rst` is asynchronous and active-high.

Behaviour:
- State per set:
  - valid[WAY_NUM].
  - plru[WAY_NUM-1], a heap-ordered tree: node n (root n=1) has children 2n and 2n+1; the bit lives at index n-1.
  - Bit=0 means the next victim is in the lower-index subtree; bit=1 means the upper subtree.
- Reset (async, i_rst=1):
  - All valid=0, all plru=0, state=IDLE.
  - o_resp_valid=0, o_resp_way=0, o_resp_evict=0, o_flush_busy=0.
  - o_alloc_ready=0 while i_rst is asserted.
- FSM IDLE:
  - o_alloc_ready = ~i_flush.
  - i_flush=1 -> FLUSH, flush index=0. Flush takes priority: no alloc is accepted that cycle.
- FSM FLUSH:
  - o_flush_busy=1, o_alloc_ready=0.
  - Each cycle clear valid and plru of set[index], then index++.
  - After clearing set SET_NUM-1 -> IDLE. Busy lasts exactly SET_NUM cycles.
  - i_flush is ignored while busy.
  - Hits and invalidations during flush are ignored.
- Allocation (on an accepted request):
  - Victim is chosen from the pre-update state of i_alloc_set.
  - If any way is invalid: lowest-index invalid way, evict=0.
  - Otherwise: walk plru from the root to a leaf, evict=1.
- Allocation update, same edge:
  - valid[set][way]=1.
  - PLRU path bits are set to point away from the granted way.
- Allocation response:
  - Registered: o_resp_valid=1 the cycle after acceptance, with way and evict.
  - o_resp_way and o_resp_evict hold their value until the next response.
  - Throughput is one allocation per cycle; back-to-back same-set requests see the prior update.
- Hit: PLRU path bits for i_hit_way are set to point away from it; valid bits are unchanged. i_hit_way=0 is a no-op.
- Invalidate: valid[i_inv_set] &= ~i_inv_way; PLRU is unchanged.
- Same-cycle, same-set events:
  - Alloc and inv: victim choice uses pre-inv state. Inv is applied, then alloc sets its way valid; alloc wins on the same way.
  - Alloc and hit: the alloc PLRU update wins on shared path bits; the hit update applies to non-shared bits.
  - Hit and inv: both apply independently.
  - Different sets: fully independent.
- Reset mid-flush: busy drops immediately and arrays are clear. A new flush is not required.

Optional Feature:
- KV_ALLOC_STATS_EN:
  - Defined: adds output o_evict_cnt [31:0] and o_alloc_cnt [31:0].
  - Counts accepted allocations with evict=1 and all accepted allocations.
  - Both saturate at 0xFFFFFFFF, are async-cleared by i_rst and are cleared by flush start.
  - Undefined: ports and counters are absent; no other change.

Test Plan:
- Reset; alloc set 5 four times back-to-back -> o_resp_way 0001, 0010, 0100, 1000, each evict=0, one cycle after each accept.
- Continue with a 5th alloc set 5 -> way 0001, evict=1.
  - PLRU after 4 fills is root=0, L=0, R=0.
  - After this alloc: root=1, L=1.
- Hit set 5 way 0100, then alloc set 5 -> way 0010, evict=1.
- Full set 9; inv way 0100 and alloc set 9 in the same cycle -> evict-based grant from pre-inv state. Next alloc set 9 -> 0100, evict=0.
- Fill several sets, assert i_flush with i_alloc_valid=1 -> ready=0, busy high exactly 64 cycles. Then alloc sets 0 and 63 -> 0001, evict=0.
- Assert i_rst at flush cycle 10 -> busy=0 and outputs zero immediately, asynchronously. After release, alloc set 40 -> 0001, evict=0.
- With KV_ALLOC_STATS_EN defined: the first two scenarios give alloc_cnt=5, evict_cnt=1.
